pixel_write_slave: RTL
======================

# pixel_write_slave

Memory-side responder for the pixel write bus driven by the Julia memory controller. It accepts single-beat 32-bit writes, applies backpressure through `wait_request` and buffers accepted pixels in a small FIFO. It decodes each byte address into a frame-buffer pixel index and drains the FIFO into an on-chip 8-bit-per-pixel frame buffer RAM port. It also counts completed frames and supports a full-frame clear sweep.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of pixel 0
- `FRAME_PIXELS`, 307200, pixels per frame (640x480)
- `ADDR_W`, 19, frame buffer index width; must satisfy 2^ADDR_W >= FRAME_PIXELS
- `FIFO_DEPTH`, 4, entries; power of 2, minimum 2

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous reset, active-high
- `write_address` in 32: byte address from bus master
- `write_data` in 32: bits [7:0] are the pixel value; bits [31:8] are ignored
- `write_enable` in 1: master write request
- `wait_request` out 1: stall; a transfer is not accepted while high
- `frame_clear` in 1: single-cycle request to zero the frame buffer
- `fb_addr` out ADDR_W: frame buffer write index
- `fb_wdata` out 8: frame buffer write data
- `fb_we` out 1: frame buffer write strobe
- `fb_stall` in 1: RAM not ready; the current `fb_*` beat is held
- `frame_done` out 1: one-cycle pulse when a frame completes
- `clear_done` out 1: one-cycle pulse when a clear sweep finishes
- `err_count` out 16: count of dropped out-of-range writes; saturating

## Operation
- Accept rule: one transfer is accepted at every rising edge where `write_enable`=1 and `wait_request`=0. A master holding `write_enable` for N unstalled cycles produces N transfers.
- Decode: `idx = write_address - BASE_ADDR`, computed as a 32-bit unsigned subtraction, so addresses below the base wrap and fail the range check.
  - If `idx < FRAME_PIXELS`: push {idx[ADDR_W-1:0], write_data[7:0]} into the FIFO.
  - Otherwise: the transfer is accepted but not pushed, and `err_count` increments. `err_count` holds at 16'hFFFF.
- Drain: while the FIFO is not empty and the FSM is in RUN or DRAIN, `fb_we`=1 and `fb_addr`/`fb_wdata` show the FIFO head. The head pops at each edge where `fb_stall`=0.
- Simultaneous push and pop: allowed in the same edge; the FIFO count is unchanged.
- `wait_request` = (FIFO full) OR (state != RUN) OR `rst`. It is combinational from registered state only; it never depends on `write_enable`.
- Pixel counter: counts in-range pops that complete (`fb_we`=1 and `fb_stall`=0).
  - On the pop that brings the count to FRAME_PIXELS: `frame_done` pulses in the following cycle and the counter returns to 0.
  - Duplicate addresses count every time they are written.
- FSM states:
  - RUN: normal operation. `frame_clear`=1 -> DRAIN.
  - DRAIN: `wait_request`=1 and the FIFO keeps draining. FIFO empty -> CLEAR, with the sweep index set to 0.
  - CLEAR: `fb_we`=1, `fb_wdata`=0, `fb_addr`=sweep index. The index advances on each edge with `fb_stall`=0. When the index FRAME_PIXELS-1 is written -> RUN; the pixel counter is set to 0 and `clear_done` pulses in the following cycle.
- `frame_clear` while in DRAIN or CLEAR: ignored.
- Reset, including mid-burst or mid-sweep, returns to a clean idle state:
  - FSM goes to RUN; the FIFO, pixel counter, sweep index and `err_count` are cleared to 0.
  - `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `frame_done`=0, `clear_done`=0.
  - `wait_request` is 1 while `rst` is high and 0 in the first cycle after release.
  - Data in flight is discarded.

## Timing
- Accept-to-RAM latency: a transfer accepted at edge k into an empty FIFO drives `fb_we`=1 in the cycle after edge k and pops at edge k+1 when `fb_stall`=0.
- Sustained throughput: one pixel per cycle when `fb_stall`=0. `wait_request` never rises in that case, because a push and a pop occur on the same edge.
- Backpressure: with `fb_stall` held at 1, exactly FIFO_DEPTH transfers are accepted. `wait_request` rises in the cycle after the FIFO_DEPTH-th accept.
- Clear sweep: lasts FRAME_PIXELS cycles plus the number of stalled cycles. `clear_done` is a single-cycle pulse.
- `frame_done` and `clear_done` are registered one-cycle pulses; they are never high for two consecutive cycles.

## Test plan
- Reset release, then write address 0x10, data 0xAB -> the next cycle shows `fb_we`=1, `fb_addr`=0x10, `fb_wdata`=0xAB; `err_count`=0.
- Hold `fb_stall`=1 and stream 6 writes -> 4 accepted (`wait_request` rises after the 4th). Release the stall -> indices drain in order, then the remaining 2 are accepted.
- Write to BASE_ADDR+307200 and to BASE_ADDR-1 -> no `fb_we` occurs and `err_count`=2. Preload `err_count` to 0xFFFF via 65535 bad writes, then send one more -> it stays at 0xFFFF.
- Run with FRAME_PIXELS=16 and 16 in-range writes -> `frame_done` pulses exactly once, one cycle after the 16th pop, and the counter returns to 0.
- With 3 entries queued, pulse `frame_clear` -> the 3 drain first, then 16 zero writes at indices 0..15 (FRAME_PIXELS=16); `wait_request`=1 throughout; `clear_done` pulses once; then RUN resumes.
- Assert `rst` mid-clear at index 7 -> all outputs take their reset values immediately. After release, `wait_request`=0 and no further zero writes occur.

Source files
------------

// File: rtl/pixel_write_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pixel_write_slave                                               |
// | Purpose  : Pixel write bus responder. Buffers single-beat writes in a      |
// |            small FIFO, decodes byte addresses to frame-buffer indices,     |
// |            drains into an 8bpp RAM port, counts frames, clears the frame.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pixel_write_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       write_address,
  input  logic [31:0]       write_data,
  input  logic              write_enable,
  output logic              wait_request,
  input  logic              frame_clear,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              fb_we,
  input  logic              fb_stall,
  output logic              frame_done,
  output logic              clear_done,
  output logic [15:0]       err_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_fifo_full = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [7:0]        r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_sweep;
  logic [ADDR_W-1:0] r_pix_cnt;

  logic [31:0] w_idx;
  logic        w_in_range;
  logic        w_empty;
  logic        w_full;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_sweep_last;
  logic        w_sweep_done;
  logic        w_pix_last;
  logic        w_unused;

  // Only the low byte of the data word carries a pixel.
  assign w_unused = ^write_data[31:8];

  // Addresses below the base wrap to huge indices and fail the range test.
  assign w_idx      = write_address - BASE_ADDR;
  assign w_in_range = (w_idx < FRAME_PIXELS);

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_fifo_full);
  assign wait_request = w_full | (r_state != S_RUN) | rst;
  assign w_accept     = write_enable & ~wait_request;
  assign w_push       = w_accept & w_in_range;
  assign w_pop        = (r_state != S_CLEAR) & ~w_empty & ~fb_stall;
  assign w_sweep_last = (r_sweep == c_last_idx);
  assign w_sweep_done = (r_state == S_CLEAR) & ~fb_stall & w_sweep_last;
  assign w_pix_last   = (r_pix_cnt == c_last_idx);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next-state and RAM port drive: FIFO head in RUN/DRAIN, zero sweep in CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    fb_we       = 1'b0;
    fb_addr     = '0;
    fb_wdata    = '0;
    case (r_state)
      S_RUN, S_DRAIN: begin
        if (!w_empty) begin
          fb_we    = 1'b1;
          fb_addr  = r_mem_addr[r_rd_ptr];
          fb_wdata = r_mem_data[r_rd_ptr];
        end
        if (r_state == S_RUN) begin
          if (frame_clear) w_state_nxt = S_DRAIN;
        end else if (w_empty) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = r_sweep;
        if (!fb_stall && w_sweep_last) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // FIFO storage; occupancy gates every read, so contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= w_idx[ADDR_W-1:0];
      r_mem_data[r_wr_ptr] <= write_data[7:0];
    end
  end

  // FIFO pointers and occupancy; push and pop on one edge leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear sweep index: zeroed on entry to CLEAR, advances per unstalled beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep <= '0;
    end else if (r_state == S_DRAIN && w_empty) begin
      r_sweep <= '0;
    end else if (r_state == S_CLEAR && !fb_stall) begin
      r_sweep <= w_sweep_last ? '0 : r_sweep + ADDR_W'(1);
    end
  end

  // Pixel counter with registered frame/clear completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt  <= '0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      if (w_sweep_done) begin
        r_pix_cnt  <= '0;
        clear_done <= 1'b1;
      end else if (w_pop) begin
        if (w_pix_last) begin
          r_pix_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Saturating count of accepted writes that fell outside the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (w_accept && !w_in_range && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
`default_nettype wire
